// File: rtl/ahb_axi_wr_arbiter.sv
// ahb_axi_wr_arbiter
// Shares one AXI write master port (AW/W/B) between NREQ single-beat write
// requesters. Grants are round-robin and only one transaction is in flight
// at a time. AW and W are issued together in the cycle after the accept
// pulse. The B response is returned to the granted requester as a
// one-cycle pulse.
//
// Optional feature: define AHB_AXI_WR_ID_TAG_EN to tag AW with the granted
// requester index. A B beat whose ID differs from that tag still completes
// the transaction, but it is reported as an error.
module ahb_axi_wr_arbiter #(
    parameter int NREQ = 2,
    parameter int AW   = 32,
    parameter int DW   = 64,
    parameter int TIDW = 1
) (
    input  logic               HCLK,
    input  logic               HRESET,
    input  logic [NREQ-1:0]    req_valid_i,
    input  logic [NREQ*AW-1:0] req_addr_i,
    input  logic [NREQ*3-1:0]  req_size_i,
    input  logic [NREQ*DW-1:0] req_data_i,
    output logic [NREQ-1:0]    req_ready_o,
    output logic [NREQ-1:0]    rsp_valid_o,
    output logic               rsp_err_o,
    output logic [TIDW-1:0]    axi_aw_id_o,
    output logic [AW-1:0]      axi_aw_addr_o,
    output logic [7:0]         axi_aw_len_o,
    output logic [2:0]         axi_aw_size_o,
    output logic [1:0]         axi_aw_burst_o,
    output logic               axi_aw_valid_o,
    input  logic               axi_aw_ready_i,
    output logic [DW-1:0]      axi_w_data_o,
    output logic [DW/8-1:0]    axi_w_strb_o,
    output logic               axi_w_last_o,
    output logic               axi_w_valid_o,
    input  logic               axi_w_ready_i,
    input  logic [TIDW-1:0]    axi_b_id_i,
    input  logic [1:0]         axi_b_resp_i,
    input  logic               axi_b_valid_i,
    output logic               axi_b_ready_o
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int SB = DW / 8;
    localparam int OW = (SB > 1) ? $clog2(SB) : 1;
    localparam logic [2:0] MAX_SIZE = 3'($clog2(SB));

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEND   = 2'd1,
        WAIT_B = 2'd2
    } state_t;

    state_t          state_reg, state_next;
    logic [IW-1:0]   ptr_reg, ptr_next;
    logic [IW-1:0]   gnt_reg, gnt_next;
    logic [AW-1:0]   addr_reg, addr_next;
    logic [2:0]      size_reg, size_next;
    logic [DW-1:0]   data_reg, data_next;
    logic [SB-1:0]   strb_reg, strb_next;
    logic            aw_done_reg, aw_done_next;
    logic            w_done_reg, w_done_next;
`ifdef AHB_AXI_WR_ID_TAG_EN
    logic [TIDW-1:0] id_reg, id_next;
`endif

    // Unpacked per-requester views of the packed request buses
    logic [AW-1:0]   addr_arr [NREQ];
    logic [2:0]      size_arr [NREQ];
    logic [DW-1:0]   data_arr [NREQ];

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign addr_arr[gi] = req_addr_i[gi*AW +: AW];
            assign size_arr[gi] = req_size_i[gi*3 +: 3];
            assign data_arr[gi] = req_data_i[gi*DW +: DW];
        end
    endgenerate

    logic            gnt_found;
    logic [IW-1:0]   gnt_idx;
    logic [IW:0]     cand;

    // Round-robin scan: the first pending requester at or after the pointer, with wrap
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        for (int i = 0; i < NREQ; i++) begin
            cand = {1'b0, ptr_reg} + (IW+1)'(i);
            if (cand >= (IW+1)'(NREQ)) begin
                cand = cand - (IW+1)'(NREQ);
            end
            if (!gnt_found && req_valid_i[cand[IW-1:0]]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand[IW-1:0];
            end
        end
    end

    logic [AW-1:0]   sel_addr;
    logic [2:0]      sel_size;
    logic [DW-1:0]   sel_data;
    logic [2:0]      size_clamp;
    logic [OW:0]     nbytes;
    logic [OW-1:0]   off_raw;
    logic [OW-1:0]   off_al;
    logic [OW:0]     off_end;
    logic [SB-1:0]   strb_calc;

    assign sel_addr = addr_arr[gnt_idx];
    assign sel_size = size_arr[gnt_idx];
    assign sel_data = data_arr[gnt_idx];

    // Clamp the size to the bus width and align the lane offset down to the transfer size
    always_comb begin
        size_clamp = (sel_size > MAX_SIZE) ? MAX_SIZE : sel_size;
        nbytes     = (OW+1)'(1) << size_clamp;
        off_raw    = (SB > 1) ? sel_addr[OW-1:0] : '0;
        off_al     = off_raw & ~(OW'(nbytes - (OW+1)'(1)));
        off_end    = {1'b0, off_al} + nbytes;
    end

    // A byte lane is enabled when it lies inside [off_al, off_al + nbytes)
    generate
        for (gi = 0; gi < SB; gi++) begin : g_strb
            localparam logic [OW:0] LANE = (OW+1)'(gi);
            assign strb_calc[gi] = (LANE >= {1'b0, off_al}) && (LANE < off_end);
        end
    endgenerate

    logic b_fire;
    logic id_mismatch;

    assign b_fire = (state_reg == WAIT_B) && axi_b_valid_i;

    // Next-state logic: accept in IDLE, track the AW and W handshakes in SEND, complete in WAIT_B
    always_comb begin
        state_next   = state_reg;
        ptr_next     = ptr_reg;
        gnt_next     = gnt_reg;
        addr_next    = addr_reg;
        size_next    = size_reg;
        data_next    = data_reg;
        strb_next    = strb_reg;
        aw_done_next = aw_done_reg;
        w_done_next  = w_done_reg;
`ifdef AHB_AXI_WR_ID_TAG_EN
        id_next      = id_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (gnt_found) begin
                    state_next   = SEND;
                    gnt_next     = gnt_idx;
                    addr_next    = sel_addr;
                    size_next    = size_clamp;
                    data_next    = sel_data;
                    strb_next    = strb_calc;
                    aw_done_next = 1'b0;
                    w_done_next  = 1'b0;
`ifdef AHB_AXI_WR_ID_TAG_EN
                    id_next      = TIDW'(gnt_idx);
`endif
                end
            end
            SEND: begin
                aw_done_next = aw_done_reg | (axi_aw_valid_o & axi_aw_ready_i);
                w_done_next  = w_done_reg | (axi_w_valid_o & axi_w_ready_i);
                if (aw_done_next && w_done_next) begin
                    state_next = WAIT_B;
                end
            end
            WAIT_B: begin
                if (axi_b_valid_i) begin
                    state_next = IDLE;
                    ptr_next   = (gnt_reg == IW'(NREQ - 1)) ? '0 : gnt_reg + IW'(1);
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State and latched-request registers; reset abandons any in-flight transaction
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_reg   <= IDLE;
            ptr_reg     <= '0;
            gnt_reg     <= '0;
            addr_reg    <= '0;
            size_reg    <= '0;
            data_reg    <= '0;
            strb_reg    <= '0;
            aw_done_reg <= 1'b0;
            w_done_reg  <= 1'b0;
`ifdef AHB_AXI_WR_ID_TAG_EN
            id_reg      <= '0;
`endif
        end else begin
            state_reg   <= state_next;
            ptr_reg     <= ptr_next;
            gnt_reg     <= gnt_next;
            addr_reg    <= addr_next;
            size_reg    <= size_next;
            data_reg    <= data_next;
            strb_reg    <= strb_next;
            aw_done_reg <= aw_done_next;
            w_done_reg  <= w_done_next;
`ifdef AHB_AXI_WR_ID_TAG_EN
            id_reg      <= id_next;
`endif
        end
    end

`ifdef AHB_AXI_WR_ID_TAG_EN
    assign axi_aw_id_o = id_reg;
    assign id_mismatch = (axi_b_id_i != id_reg);
`else
    logic unused_b_id;
    assign axi_aw_id_o = '0;
    assign id_mismatch = 1'b0;
    assign unused_b_id = ^axi_b_id_i;
`endif

    // One-hot accept and completion pulses. Accept is masked while reset is
    // held, because it depends directly on the request inputs.
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_onehot
            assign req_ready_o[gi] = (state_reg == IDLE) && gnt_found &&
                                     (gnt_idx == IW'(gi)) && !HRESET;
            assign rsp_valid_o[gi] = b_fire && (gnt_reg == IW'(gi));
        end
    endgenerate

    assign rsp_err_o      = b_fire && (axi_b_resp_i[1] || id_mismatch);
    assign axi_aw_addr_o  = addr_reg;
    assign axi_aw_len_o   = 8'd0;
    assign axi_aw_size_o  = size_reg;
    assign axi_aw_burst_o = 2'b01;
    assign axi_aw_valid_o = (state_reg == SEND) && !aw_done_reg;
    assign axi_w_data_o   = data_reg;
    assign axi_w_strb_o   = strb_reg;
    assign axi_w_last_o   = 1'b1;
    assign axi_w_valid_o  = (state_reg == SEND) && !w_done_reg;
    assign axi_b_ready_o  = (state_reg == WAIT_B);

endmodule
